// File: rtl/line_write_buffer.sv
// rtl/line_write_buffer.sv - single-line write-combining buffer; LWB_AUTO_DRAIN_EN enables automatic drain of fully written lines
module line_write_buffer #(
   parameter int LINE_BYTES = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [31:0]             wr_addr,
   input  logic [31:0]             wr_data,
   input  logic [3:0]              wr_mbe,
   output logic                    wr_stall,
   input  logic                    flush,
   output logic                    empty,
   output logic                    mem_write,
   output logic [31:0]             mem_address,
   output logic [LINE_BYTES*8-1:0] mem_wdata,
   output logic [LINE_BYTES-1:0]   mem_byte_en,
   input  logic                    mem_resp
);

   localparam int OFF_BITS = $clog2(LINE_BYTES);
   localparam int TAG_BITS = 32 - OFF_BITS;
   localparam int WIDX_BITS = OFF_BITS - 2;

   typedef enum logic [1:0] {
      S_EMPTY,
      S_FILL,
      S_DRAIN
   } state_t;

   state_t                  state;
   logic [TAG_BITS-1:0]     tag;
   logic [LINE_BYTES*8-1:0] data;
   logic [LINE_BYTES-1:0]   mask;

   logic [TAG_BITS-1:0]     wr_tag;
   logic [WIDX_BITS-1:0]    word_idx;
   logic                    tag_miss;
   logic                    accept;
   logic [LINE_BYTES*8-1:0] merge_data;
   logic [LINE_BYTES-1:0]   merge_mask;
   logic [LINE_BYTES-1:0]   next_mask;
   logic                    line_full;
   logic                    unused_addr_bits;

   assign wr_tag   = wr_addr[31:OFF_BITS];
   assign word_idx = wr_addr[OFF_BITS-1:2];
   assign unused_addr_bits = &{1'b0, wr_addr[1:0]};

   assign tag_miss = (wr_tag != tag);

   // A store is refused while the line drains, or while filling a different line
   assign wr_stall = wr_en & ((state == S_DRAIN) | ((state == S_FILL) & tag_miss));
   assign accept   = wr_en & ~wr_stall;

   // Merge the incoming word lanes into the held line; a fresh line starts from an empty mask
   always_comb begin
      int b;
      merge_data = data;
      merge_mask = (state == S_EMPTY) ? '0 : mask;
      for (int i = 0; i < 4; i++) begin
         b = 4 * int'(word_idx) + i;
         if (wr_mbe[i]) begin
            merge_data[8*b +: 8] = wr_data[8*i +: 8];
            merge_mask[b]        = 1'b1;
         end
      end
   end

   assign next_mask = accept ? merge_mask : mask;

`ifdef LWB_AUTO_DRAIN_EN
   assign line_full = &next_mask;
`else
   assign line_full = 1'b0 & (&next_mask);
`endif

   // Buffer state machine; mem_write and empty are registered alongside the state
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_EMPTY;
         tag       <= '0;
         data      <= '0;
         mask      <= '0;
         mem_write <= 1'b0;
         empty     <= 1'b1;
      end else begin
         case (state)
            S_EMPTY: begin
               if (accept) begin
                  tag   <= wr_tag;
                  data  <= merge_data;
                  mask  <= merge_mask;
                  state <= S_FILL;
                  empty <= 1'b0;
               end
            end
            S_FILL: begin
               if (accept) begin
                  data <= merge_data;
                  mask <= merge_mask;
               end
               if (flush || (wr_en && tag_miss) || line_full) begin
                  state     <= S_DRAIN;
                  mem_write <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (mem_resp) begin
                  mask      <= '0;
                  state     <= S_EMPTY;
                  mem_write <= 1'b0;
                  empty     <= 1'b1;
               end
            end
            default: begin
               state     <= S_EMPTY;
               mem_write <= 1'b0;
               empty     <= 1'b1;
            end
         endcase
      end
   end

   assign mem_address = {tag, {OFF_BITS{1'b0}}};
   assign mem_wdata   = data;
   assign mem_byte_en = mask;

endmodule

// File: tb/tb_line_write_buffer.sv
// tb/tb_line_write_buffer.sv - self-checking bench for line_write_buffer
module tb_line_write_buffer;

   localparam bit AUTO =
`ifdef LWB_AUTO_DRAIN_EN
      1'b1;
`else
      1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         wr_en;
   logic [31:0]  wr_addr;
   logic [31:0]  wr_data;
   logic [3:0]   wr_mbe;
   logic         wr_stall;
   logic         flush;
   logic         empty;
   logic         mem_write;
   logic [31:0]  mem_address;
   logic [255:0] mem_wdata;
   logic [31:0]  mem_byte_en;
   logic         mem_resp;

   int n_checks = 0;
   int n_fail   = 0;

   line_write_buffer #(.LINE_BYTES(32)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_mbe(wr_mbe), .wr_stall(wr_stall), .flush(flush), .empty(empty),
      .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_byte_en(mem_byte_en), .mem_resp(mem_resp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        wr_en;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mbe;
      logic        flush;
      logic        resp;
      logic        exp_stall;
      logic        exp_mw;
      logic        exp_empty;
      logic [31:0] exp_be;
      logic [31:0] exp_addr;
      int          chk_word;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(logic we, logic [31:0] a, logic [31:0] d, logic [3:0] m,
                               logic fl, logic rs, logic st, logic mw, logic em,
                               logic [31:0] be, logic [31:0] ea, int cw, logic [31:0] ew);
      vec_t v;
      v.wr_en = we; v.addr = a; v.data = d; v.mbe = m; v.flush = fl; v.resp = rs;
      v.exp_stall = st; v.exp_mw = mw; v.exp_empty = em; v.exp_be = be; v.exp_addr = ea;
      v.chk_word = cw; v.exp_word = ew;
      return v;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mbe = '0; flush = 1'b0; mem_resp = 1'b0;
   endtask

   // behavioural model of the buffer contents
   bit          m_hold, m_drain;
   logic [26:0] m_tag;
   logic [7:0]  m_data [32];
   bit          m_valid [32];

   task automatic model_reset();
      m_hold = 0; m_drain = 0; m_tag = '0;
      for (int i = 0; i < 32; i++) begin
         m_data[i] = 8'h00; m_valid[i] = 0;
      end
   endtask

   initial begin
      logic [31:0]  d3;
      logic         e_stall, acc, was_hold, all_v;
      logic [31:0]  e_be;
      logic [255:0] e_wd;
      int           b;

      idle();
      rst = 1'b1;
      tick();
      tick();
      chk("reset_mem_write", mem_write, 1'b0);
      chk("reset_empty", empty, 1'b1);
      chk("reset_byte_en", mem_byte_en, 32'h0);
      chk("reset_address", mem_address, 32'h0);
      chk("reset_wdata", mem_wdata, 256'h0);
      rst = 1'b0;

      //             we  addr          data          mbe    fl rs st mw em be            addr          word value
      vecs[0]  = mk(0, 32'h0,        32'h0,        4'h0, 0, 0, 0, 0, 1, 32'h0,        32'h0,     -1, 32'h0);
      vecs[1]  = mk(1, 32'h1004,     32'hAABBCCDD, 4'hF, 0, 0, 0, 0, 0, 32'hF0,       32'h1000,  -1, 32'h0);
      vecs[2]  = mk(0, 32'h0,        32'h0,        4'h0, 1, 0, 0, 1, 0, 32'hF0,       32'h1000,   1, 32'hAABBCCDD);
      vecs[3]  = mk(1, 32'h1008,     32'h0,        4'hF, 0, 0, 1, 1, 0, 32'hF0,       32'h1000,  -1, 32'h0);
      vecs[4]  = mk(0, 32'h0,        32'h0,        4'h0, 0, 1, 0, 0, 1, 32'h0,        32'h1000,  -1, 32'h0);
      vecs[5]  = mk(0, 32'h0,        32'h0,        4'h0, 1, 0, 0, 0, 1, 32'h0,        32'h1000,  -1, 32'h0);
      vecs[6]  = mk(1, 32'h1000,     32'h11,       4'h1, 0, 0, 0, 0, 0, 32'h1,        32'h1000,  -1, 32'h0);
      vecs[7]  = mk(1, 32'h1000,     32'h22,       4'h1, 0, 0, 0, 0, 0, 32'h1,        32'h1000,  -1, 32'h0);
      vecs[8]  = mk(0, 32'h0,        32'h0,        4'h0, 1, 0, 0, 1, 0, 32'h1,        32'h1000,   0, 32'h22);
      vecs[9]  = mk(0, 32'h0,        32'h0,        4'h0, 0, 1, 0, 0, 1, 32'h0,        32'h1000,  -1, 32'h0);
      vecs[10] = mk(1, 32'h1000,     32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, 0, 32'h0,        32'h1000,  -1, 32'h0);
      vecs[11] = mk(1, 32'h2000,     32'h44332211, 4'hF, 0, 0, 1, 1, 0, 32'h0,        32'h1000,   0, 32'h22);
      vecs[12] = mk(1, 32'h2000,     32'h44332211, 4'hF, 0, 1, 1, 0, 1, 32'h0,        32'h1000,  -1, 32'h0);
      vecs[13] = mk(1, 32'h2000,     32'h44332211, 4'hF, 0, 0, 0, 0, 0, 32'hF,        32'h2000,  -1, 32'h0);
      vecs[14] = mk(1, 32'h2004,     32'h99887766, 4'h3, 1, 0, 0, 1, 0, 32'h3F,       32'h2000,   0, 32'h44332211);
      vecs[15] = mk(0, 32'h0,        32'h0,        4'h0, 0, 1, 0, 0, 1, 32'h0,        32'h2000,  -1, 32'h0);

      for (int i = 0; i < 16; i++) begin
         wr_en = vecs[i].wr_en; wr_addr = vecs[i].addr; wr_data = vecs[i].data;
         wr_mbe = vecs[i].mbe; flush = vecs[i].flush; mem_resp = vecs[i].resp;
         #2;
         chk($sformatf("vec%0d_stall", i), wr_stall, vecs[i].exp_stall);
         tick();
         chk($sformatf("vec%0d_mem_write", i), mem_write, vecs[i].exp_mw);
         chk($sformatf("vec%0d_empty", i), empty, vecs[i].exp_empty);
         chk($sformatf("vec%0d_byte_en", i), mem_byte_en, vecs[i].exp_be);
         chk($sformatf("vec%0d_address", i), mem_address, vecs[i].exp_addr);
         if (vecs[i].chk_word >= 0)
            chk($sformatf("vec%0d_word", i), mem_wdata[32*vecs[i].chk_word +: 32], vecs[i].exp_word);
      end
      idle();

      // reset in the middle of a drain abandons the line
      wr_en = 1'b1; wr_addr = 32'h6000; wr_data = 32'h12345678; wr_mbe = 4'hF;
      tick();
      idle(); flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("rst_drain_pre_mw", mem_write, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_drain_mw", mem_write, 1'b0);
      chk("rst_drain_empty", empty, 1'b1);
      chk("rst_drain_be", mem_byte_en, 32'h0);
      chk("rst_drain_addr", mem_address, 32'h0);
      chk("rst_drain_wdata", mem_wdata, 256'h0);
      mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0;
      chk("late_resp_mw", mem_write, 1'b0);
      chk("late_resp_empty", empty, 1'b1);
      chk("late_resp_be", mem_byte_en, 32'h0);

      // eight full-word writes cover the whole line
      d3 = 32'h0;
      for (int w = 0; w < 8; w++) begin
         wr_en = 1'b1; wr_addr = 32'h3000 + 32'(4 * w); wr_data = $urandom; wr_mbe = 4'hF;
         if (w == 3) d3 = wr_data;
         tick();
         chk($sformatf("full_w%0d_mw", w), mem_write, AUTO && (w == 7));
      end
      idle();
      if (!AUTO) begin
         tick();
         chk("full_no_flush_mw", mem_write, 1'b0);
         flush = 1'b1;
         tick();
         flush = 1'b0;
      end
      chk("full_mw", mem_write, 1'b1);
      chk("full_be", mem_byte_en, 32'hFFFFFFFF);
      chk("full_addr", mem_address, 32'h3000);
      chk("full_word3", mem_wdata[127:96], d3);
      mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0;
      chk("full_done_empty", empty, 1'b1);

      // randomized traffic against the behavioural model
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 600; c++) begin
         wr_en    = ($urandom_range(0, 9) < 6);
         wr_addr  = ($urandom_range(0, 1) ? 32'h4000 : 32'h5000) + 32'($urandom_range(0, 31));
         wr_data  = $urandom;
         wr_mbe   = 4'($urandom_range(0, 15));
         flush    = ($urandom_range(0, 9) == 0);
         mem_resp = m_drain && ($urandom_range(0, 1) == 1);
         e_stall  = wr_en && (m_drain || (m_hold && (wr_addr[31:5] != m_tag)));
         #2;
         chk("rnd_stall", wr_stall, e_stall);
         acc = wr_en && !e_stall;
         if (m_drain) begin
            if (mem_resp) begin
               m_drain = 0; m_hold = 0;
               for (int i = 0; i < 32; i++) m_valid[i] = 0;
            end
         end else begin
            was_hold = m_hold;
            if (acc) begin
               if (!m_hold) begin
                  m_tag = wr_addr[31:5]; m_hold = 1;
                  for (int i = 0; i < 32; i++) m_valid[i] = 0;
               end
               for (int i = 0; i < 4; i++) begin
                  if (wr_mbe[i]) begin
                     b = int'(wr_addr[4:2]) * 4 + i;
                     m_data[b] = wr_data[8*i +: 8];
                     m_valid[b] = 1;
                  end
               end
            end
            if (was_hold && (flush || e_stall)) m_drain = 1;
            all_v = 1;
            for (int i = 0; i < 32; i++) if (!m_valid[i]) all_v = 0;
            if (AUTO && m_hold && all_v) m_drain = 1;
         end
         tick();
         e_be = '0;
         for (int i = 0; i < 32; i++) begin
            e_be[i] = m_valid[i];
            e_wd[8*i +: 8] = m_data[i];
         end
         chk("rnd_mem_write", mem_write, m_drain);
         chk("rnd_empty", empty, !m_hold);
         chk("rnd_byte_en", mem_byte_en, e_be);
         chk("rnd_address", mem_address, {m_tag, 5'b0});
         chk("rnd_wdata", mem_wdata, e_wd);
      end
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
